// File: rtl/mult_booth.sv
// Iterative radix-2 Booth signed multiplier (32x32 -> low 32 bits + overflow flag).
// Latency: 32 cycles from the start edge to data_resultRDY; one add/shift step per cycle.
// No backpressure: ctrl_MULT restarts the operation in any state; the result is held until the next start.
//
// Ports:
//   clock, reset        - single clock, synchronous active-high reset
//   ctrl_MULT           - start pulse, latches data_operandA (M) and data_operandB (Q)
//   data_operandA/B     - signed 32-bit multiplicand / multiplier
//   data_result         - product bits [31:0]
//   data_exception      - product does not fit in a signed 32-bit value
//   data_resultRDY      - one-cycle result-valid pulse
//   busy                - high while the step loop is running

// 32-bit carry-lookahead adder: 4-bit lookahead groups chained by group carries.
// o_ovf is the signed overflow (carry into bit 31 XOR carry out of bit 31).
module cla_add (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_cin,
  output logic [31:0] o_sum,
  output logic        o_ovf
);
  logic [31:0] w_g;
  logic [31:0] w_p;
  logic [32:0] w_c;
  logic [7:0]  w_gg;
  logic [7:0]  w_gp;

  always_comb begin
    w_g  = i_a & i_b;
    w_p  = i_a ^ i_b;
    w_c  = '0;
    w_gg = '0;
    w_gp = '0;
    w_c[0] = i_cin;
    for (int k = 0; k < 8; k++) begin
      w_c[4*k+1] = w_g[4*k] | (w_p[4*k] & w_c[4*k]);
      w_c[4*k+2] = w_g[4*k+1] | (w_p[4*k+1] & w_g[4*k])
                 | (w_p[4*k+1] & w_p[4*k] & w_c[4*k]);
      w_c[4*k+3] = w_g[4*k+2] | (w_p[4*k+2] & w_g[4*k+1])
                 | (w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                 | (w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & w_c[4*k]);
      w_gg[k]    = w_g[4*k+3] | (w_p[4*k+3] & w_g[4*k+2])
                 | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
                 | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k]);
      w_gp[k]    = &w_p[4*k +: 4];
      w_c[4*k+4] = w_gg[k] | (w_gp[k] & w_c[4*k]);
    end
  end

  assign o_sum = w_p ^ w_c[31:0];
  assign o_ovf = w_c[32] ^ w_c[31];
endmodule

module mult_booth (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_MULT,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_m;
  logic [31:0] r_a;
  logic [31:0] r_q;
  logic        r_q1;
  logic [5:0]  r_cnt;

  logic [31:0] w_add_b;
  logic        w_add_cin;
  logic [31:0] w_sum;
  logic        w_ovf;
  logic        w_ext;
  logic [32:0] w_hi;

  // Booth recoding of {Q[0], q_1}: 01 adds M, 10 subtracts M (~M + 1), else adds 0.
  // The adder is always driven; its result only matters in RUN.
  always_comb begin
    w_add_b   = '0;
    w_add_cin = 1'b0;
    case ({r_q[0], r_q1})
      2'b01: begin
        w_add_b   = r_m;
        w_add_cin = 1'b0;
      end
      2'b10: begin
        w_add_b   = ~r_m;
        w_add_cin = 1'b1;
      end
      default: begin
        w_add_b   = '0;
        w_add_cin = 1'b0;
      end
    endcase
  end

  cla_add u_cla_add (
    .i_a   (r_a),
    .i_b   (w_add_b),
    .i_cin (w_add_cin),
    .o_sum (w_sum),
    .o_ovf (w_ovf)
  );

  // True sign of the 33-bit sum: a signed overflow flips the visible bit 31.
  // This keeps the arithmetic shift correct when A +/- M leaves 32-bit range.
  assign w_ext = w_sum[31] ^ w_ovf;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (ctrl_MULT) begin
      w_state_nxt = S_RUN;
    end else begin
      case (r_state)
        S_RUN:   if (r_cnt == 6'd31) w_state_nxt = S_DONE;
        S_DONE:  w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_m   <= '0;
      r_a   <= '0;
      r_q   <= '0;
      r_q1  <= 1'b0;
      r_cnt <= '0;
    end else if (ctrl_MULT) begin
      r_m   <= data_operandA;
      r_a   <= '0;
      r_q   <= data_operandB;
      r_q1  <= 1'b0;
      r_cnt <= '0;
    end else if (r_state == S_RUN) begin
      r_a   <= {w_ext, w_sum[31:1]};
      r_q   <= {w_sum[0], r_q[31:1]};
      r_q1  <= r_q[0];
      r_cnt <= r_cnt + 6'd1;
    end
  end

  // The product fits in 32 signed bits only when bits [63:31] are a pure sign extension.
  assign w_hi           = {r_a, r_q[31]};
  assign data_result    = r_q;
  assign data_exception = ~((&w_hi) | ~(|w_hi));
  assign data_resultRDY = (r_state == S_DONE);
  assign busy           = (r_state == S_RUN);
endmodule

// File: tb/tb_mult_booth.sv
module tb_mult_booth;
  logic        clock = 1'b0;
  logic        reset;
  logic        ctrl_MULT;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  mult_booth dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=0x%0h want=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: full 64-bit signed product; exception when it is not a sign-extended 32-bit value.
  task automatic ref_mul(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic exc);
    longint p;
    longint lo;
    p   = longint'($signed(a)) * longint'($signed(b));
    res = p[31:0];
    lo  = longint'($signed(p[31:0]));
    exc = (p != lo);
  endtask

  // Called at posedge+1; returns at posedge+1 of the last edge that sampled ctrl_MULT high.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input int hold);
    ctrl_MULT     = 1'b1;
    data_operandA = a;
    data_operandB = b;
    repeat (hold) @(posedge clock);
    #1 ctrl_MULT = 1'b0;
  endtask

  // Waits (bounded) for RDY after the start edge; checks latency, busy, result, single pulse.
  task automatic wait_rdy(input string tag, input logic [31:0] er, input logic ee);
    int k;
    int busy_bad;
    k = 0;
    busy_bad = 0;
    while (data_resultRDY !== 1'b1 && k < 40) begin
      if (busy !== 1'b1) busy_bad++;
      @(posedge clock);
      #1;
      k++;
    end
    chk({tag, "_latency"}, 64'(k), 64'd32);
    chk({tag, "_busy_run"}, 64'(busy_bad), 64'd0);
    chk({tag, "_result"}, 64'(data_result), 64'(er));
    chk({tag, "_exc"}, 64'(data_exception), 64'(ee));
    chk({tag, "_busy_rdy"}, 64'(busy), 64'd0);
    @(posedge clock);
    #1;
    chk({tag, "_rdy_pulse"}, 64'(data_resultRDY), 64'd0);
    chk({tag, "_hold_result"}, 64'(data_result), 64'(er));
  endtask

  task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] er;
    logic        ee;
    ref_mul(a, b, er, ee);
    start_op(a, b, 1);
    wait_rdy(tag, er, ee);
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0: v = 32'h0000_0000;
      1: v = 32'h0000_0001;
      2: v = 32'hFFFF_FFFF;
      3: v = 32'h7FFF_FFFF;
      4: v = 32'h8000_0000;
      5: v = 32'h0000_FFFF & $urandom;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int spurious;
    logic [31:0] a;
    logic [31:0] b;

    reset = 1'b1;
    ctrl_MULT = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_result", 64'(data_result), 64'd0);
    chk("reset_exc", 64'(data_exception), 64'd0);
    chk("reset_rdy", 64'(data_resultRDY), 64'd0);

    // Directed cases with hand-derived expectations.
    start_op(32'd3, 32'hFFFF_FFFB, 1);
    wait_rdy("m3_n5", 32'hFFFF_FFF1, 1'b0);
    start_op(32'h7FFF_FFFF, 32'd2, 1);
    wait_rdy("max_x2", 32'hFFFF_FFFE, 1'b1);
    start_op(32'h0001_0000, 32'h0001_0000, 1);
    wait_rdy("2p16_sq", 32'h0000_0000, 1'b1);
    start_op(32'h8000_0000, 32'hFFFF_FFFF, 1);
    wait_rdy("min_xn1", 32'h8000_0000, 1'b1);
    start_op(32'h8000_0000, 32'd1, 1);
    wait_rdy("min_x1", 32'h8000_0000, 1'b0);

    // Abort at step 10: only the restarted operation may produce RDY.
    start_op(32'd7, 32'd9, 1);
    spurious = 0;
    repeat (9) begin
      @(posedge clock);
      #1;
      if (data_resultRDY !== 1'b0) spurious++;
    end
    start_op(32'hFFFF_FFFA, 32'hFFFF_FFF9, 1);
    chk("abort_no_rdy", 64'(spurious), 64'd0);
    wait_rdy("abort", 32'd42, 1'b0);

    // ctrl_MULT held for 3 edges: latency counted from the last high sample.
    start_op(32'hFFFF_FFFF, 32'h8000_0001, 3);
    wait_rdy("held", 32'h7FFF_FFFF, 1'b0);

    // Reset at step 20.
    start_op(32'd12345, 32'd678, 1);
    repeat (19) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_result", 64'(data_result), 64'd0);
    chk("rst_mid_exc", 64'(data_exception), 64'd0);
    spurious = 0;
    repeat (40) begin
      if (data_resultRDY !== 1'b0) spurious++;
      @(posedge clock);
      #1;
    end
    chk("rst_mid_no_rdy", 64'(spurious), 64'd0);
    start_op(32'd0, 32'd0, 1);
    wait_rdy("after_rst", 32'd0, 1'b0);

    // Random regression against the 64-bit reference product.
    for (int i = 0; i < 800; i++) begin
      a = pick();
      b = pick();
      run_one("rand", a, b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
